// File: rtl/bitplane_fetch_addr_gen_pkg.sv
// Shared definitions for the bitplane fetch address generator: video modes,
// control-byte offsets and the per-mode pixel-group geometry.
package bitplane_fetch_addr_gen_pkg;

    typedef enum logic [3:0] {
        MODE_OFF   = 4'd0,
        MODE_1BPP  = 4'd1,
        MODE_2BPP  = 4'd2,
        MODE_4BPP  = 4'd3,
        MODE_8BPP  = 4'd4,
        MODE_16BPP = 4'd5,
        MODE_2B8P  = 4'd6
    } video_mode_e;

    localparam int REG_MODE       = 0;
    localparam int REG_BASE_HI    = 1;
    localparam int REG_BASE_MID   = 2;
    localparam int REG_BASE_LO    = 3;
    localparam int REG_STRIDE_HI  = 4;
    localparam int REG_STRIDE_LO  = 5;
    localparam int REG_HSCALE     = 6;
    localparam int REG_VSCALE     = 7;
    localparam int NUM_CTRL_BYTES = 8;

    // Bytes fetched per pixel group; zero means the layer is off.
    function automatic logic [1:0] bytes_per_group(input logic [3:0] mode);
        case (mode)
            MODE_1BPP, MODE_2BPP, MODE_4BPP, MODE_8BPP: bytes_per_group = 2'd1;
            MODE_16BPP, MODE_2B8P:                      bytes_per_group = 2'd2;
            default:                                    bytes_per_group = 2'd0;
        endcase
    endfunction

    // Pixels per group minus one; groups are powers of two so this is a mask.
    function automatic logic [2:0] px_group_mask(input logic [3:0] mode);
        case (mode)
            MODE_1BPP, MODE_2B8P:  px_group_mask = 3'd7;
            MODE_2BPP:             px_group_mask = 3'd3;
            MODE_4BPP:             px_group_mask = 3'd1;
            default:               px_group_mask = 3'd0;
        endcase
    endfunction

    function automatic logic mode_is_on(input logic [3:0] mode);
        mode_is_on = (bytes_per_group(mode) != 2'd0);
    endfunction

endpackage

// File: rtl/bitplane_fetch_addr_gen_if.sv
// Bus bundle between the raster timing / register file and the fetch address
// generator: pixel-clock phase, display enables, control bytes and fetch outputs.
interface bitplane_fetch_addr_gen_if #(
    parameter int HW_REGS_SIZE = 8,
    parameter int ADDR_SIZE    = 20
);
    logic [3:0]           pc_ena;
    logic                 hde_in;
    logic                 vde_in;
    logic [7:0]           GPU_HW_Control_regs [2 ** HW_REGS_SIZE];
    logic [ADDR_SIZE-1:0] read_addr;
    logic                 read_ena;
    logic                 pixel_out_ena;
    logic                 enable_out;
    logic [9:0]           x_out;

    modport master (
        output pc_ena, hde_in, vde_in, GPU_HW_Control_regs,
        input  read_addr, read_ena, pixel_out_ena, enable_out, x_out
    );

    modport slave (
        input  pc_ena, hde_in, vde_in, GPU_HW_Control_regs,
        output read_addr, read_ena, pixel_out_ena, enable_out, x_out
    );
endinterface

// File: rtl/bitplane_fetch_addr_gen_pixel_pipe_delay.sv
// Fixed-depth shift register that advances once per pixel period, used to line
// up per-pixel side information with RAM read data.
module pixel_pipe_delay #(
    parameter int WIDTH      = 12,
    parameter int PIPE_DELAY = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sr_q [PIPE_DELAY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) sr_q[i] <= '0;
        end else if (adv_i) begin
            sr_q[0] <= d_i;
            for (int i = 1; i < PIPE_DELAY; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    assign q_o = sr_q[PIPE_DELAY-1];
endmodule

// File: rtl/bitplane_fetch_addr_gen.sv
// Walks the raster for one bitplane layer, issuing GPU RAM read addresses and
// delaying pixel/layer enables and virtual x so they meet the returned data.
module bitplane_fetch_addr_gen
    import bitplane_fetch_addr_gen_pkg::*;
#(
    parameter logic [7:0] CTRL_BYTE_BASE = 8'h0,
    parameter int         HW_REGS_SIZE   = 8,
    parameter int         ADDR_SIZE      = 20,
    parameter int         PIPE_DELAY     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    bitplane_fetch_addr_gen_if.slave bus
);
    logic [7:0] ctrl_b [NUM_CTRL_BYTES];

    for (genvar g = 0; g < NUM_CTRL_BYTES; g++) begin : g_ctrl
        localparam int IDX = (int'(CTRL_BYTE_BASE) + g) % (2 ** HW_REGS_SIZE);
        assign ctrl_b[g] = bus.GPU_HW_Control_regs[IDX];
    end

    logic [3:0]           mode_w;
    logic [ADDR_SIZE-1:0] base_w;
    logic [ADDR_SIZE-1:0] stride_w;
    logic                 unused_ctrl_hi;

    assign mode_w   = ctrl_b[REG_MODE][3:0];
    assign base_w   = ADDR_SIZE'({ctrl_b[REG_BASE_HI], ctrl_b[REG_BASE_MID], ctrl_b[REG_BASE_LO]});
    assign stride_w = ADDR_SIZE'({ctrl_b[REG_STRIDE_HI], ctrl_b[REG_STRIDE_LO]});
    assign unused_ctrl_hi = ^{ctrl_b[REG_MODE][7:4], ctrl_b[REG_HSCALE][7:4], ctrl_b[REG_VSCALE][7:4]};

    logic                 hde_q, hde_d;
    logic                 vde_q, vde_d;
    logic                 armed_q, armed_d;
    logic [ADDR_SIZE-1:0] line_base_q, line_base_d;
    logic [ADDR_SIZE-1:0] byte_off_q, byte_off_d;
    logic [ADDR_SIZE-1:0] stride_q, stride_d;
    logic [3:0]           hscale_q, hscale_d;
    logic [3:0]           vscale_q, vscale_d;
    logic [3:0]           hrep_q, hrep_d;
    logic [3:0]           vrep_q, vrep_d;
    logic [9:0]           vx_q, vx_d;
    logic [ADDR_SIZE-1:0] read_addr_q, read_addr_d;
    logic                 read_ena_q, read_ena_d;
    logic                 pix_iss_q, pix_iss_d;
    logic                 en_iss_q, en_iss_d;
    logic [9:0]           x_iss_q, x_iss_d;

    logic       tick, disp, active, line_end, frame_start;
    logic [9:0] vx_nxt;

    assign tick        = (bus.pc_ena == 4'd0);
    assign disp        = bus.hde_in & bus.vde_in;
    // Nothing is fetched until a frame start has latched base/stride/scale.
    assign active      = disp & armed_q & mode_is_on(mode_w);
    assign line_end    = hde_q & ~bus.hde_in & vde_q;
    assign frame_start = vde_q & ~bus.vde_in;
    assign vx_nxt      = vx_q + 10'd1;

    always_comb begin
        hde_d       = hde_q;
        vde_d       = vde_q;
        armed_d     = armed_q;
        line_base_d = line_base_q;
        byte_off_d  = byte_off_q;
        stride_d    = stride_q;
        hscale_d    = hscale_q;
        vscale_d    = vscale_q;
        hrep_d      = hrep_q;
        vrep_d      = vrep_q;
        vx_d        = vx_q;
        read_addr_d = read_addr_q;
        read_ena_d  = 1'b0;
        pix_iss_d   = pix_iss_q;
        en_iss_d    = en_iss_q;
        x_iss_d     = x_iss_q;

        if (tick) begin
            hde_d     = bus.hde_in;
            vde_d     = bus.vde_in;
            pix_iss_d = disp & armed_q;
            en_iss_d  = active;
            x_iss_d   = vx_q;

            if (active) begin
                read_addr_d = line_base_q + byte_off_q;
                read_ena_d  = 1'b1;
                if (hrep_q == hscale_q) begin
                    hrep_d = 4'd0;
                    vx_d   = vx_nxt;
                    if ((vx_nxt[2:0] & px_group_mask(mode_w)) == 3'd0)
                        byte_off_d = byte_off_q + ADDR_SIZE'(bytes_per_group(mode_w));
                end else begin
                    hrep_d = hrep_q + 4'd1;
                end
            end

            // Line end is applied before frame start so a coincident frame start wins.
            if (line_end) begin
                vx_d       = '0;
                hrep_d     = '0;
                byte_off_d = '0;
                if (vrep_q == vscale_q) begin
                    vrep_d      = '0;
                    line_base_d = line_base_q + stride_q;
                end else begin
                    vrep_d = vrep_q + 4'd1;
                end
            end

            if (frame_start) begin
                armed_d     = 1'b1;
                line_base_d = base_w;
                stride_d    = stride_w;
                hscale_d    = ctrl_b[REG_HSCALE][3:0];
                vscale_d    = ctrl_b[REG_VSCALE][3:0];
                vrep_d      = '0;
                vx_d        = '0;
                hrep_d      = '0;
                byte_off_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hde_q       <= 1'b0;
            vde_q       <= 1'b0;
            armed_q     <= 1'b0;
            line_base_q <= '0;
            byte_off_q  <= '0;
            stride_q    <= '0;
            hscale_q    <= '0;
            vscale_q    <= '0;
            hrep_q      <= '0;
            vrep_q      <= '0;
            vx_q        <= '0;
            read_addr_q <= '0;
            read_ena_q  <= 1'b0;
            pix_iss_q   <= 1'b0;
            en_iss_q    <= 1'b0;
            x_iss_q     <= '0;
        end else begin
            hde_q       <= hde_d;
            vde_q       <= vde_d;
            armed_q     <= armed_d;
            line_base_q <= line_base_d;
            byte_off_q  <= byte_off_d;
            stride_q    <= stride_d;
            hscale_q    <= hscale_d;
            vscale_q    <= vscale_d;
            hrep_q      <= hrep_d;
            vrep_q      <= vrep_d;
            vx_q        <= vx_d;
            read_addr_q <= read_addr_d;
            read_ena_q  <= read_ena_d;
            pix_iss_q   <= pix_iss_d;
            en_iss_q    <= en_iss_d;
            x_iss_q     <= x_iss_d;
        end
    end

    // Issue stage -> PIPE_DELAY pixel periods -> raster stage
    logic [11:0] dly_q;

    pixel_pipe_delay #(
        .WIDTH      (12),
        .PIPE_DELAY (PIPE_DELAY)
    ) u_pipe_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .adv_i   (tick),
        .d_i     ({pix_iss_q, en_iss_q, x_iss_q}),
        .q_o     (dly_q)
    );

    assign bus.read_addr     = read_addr_q;
    assign bus.read_ena      = read_ena_q;
    assign bus.pixel_out_ena = dly_q[11];
    assign bus.enable_out    = dly_q[10];
    assign bus.x_out         = dly_q[9:0];

endmodule

// File: tb/tb_bitplane_fetch_addr_gen.sv
// Bench for bitplane_fetch_addr_gen: fixed vector table, hand-written corner
// sequences and random frames checked against a closed-form raster model.
module tb_bitplane_fetch_addr_gen;
    localparam int         PD  = 3;
    localparam int         AW  = 20;
    localparam int         HWR = 8;
    localparam logic [7:0] CB  = 8'h10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bitplane_fetch_addr_gen_if #(.HW_REGS_SIZE(HWR), .ADDR_SIZE(AW)) bus ();

    bitplane_fetch_addr_gen #(
        .CTRL_BYTE_BASE (CB),
        .HW_REGS_SIZE   (HWR),
        .ADDR_SIZE      (AW),
        .PIPE_DELAY     (PD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         pix;
        bit         en;
        logic [9:0] x;
    } dly_t;

    dly_t   hist[$];
    int     cur_mode;
    longint l_base, l_stride;
    int     l_hs, l_vs;
    longint r_base, r_stride;
    int     r_hs, r_vs;
    bit     armed, prev_h, prev_v;
    int     px_cnt, line_cnt;

    logic        s_ena, s_pix, s_en;
    logic [19:0] s_addr;
    logic [9:0]  s_x;

    function automatic int bpg(input int m);
        case (m)
            1, 2, 3, 4: return 1;
            5, 6:       return 2;
            default:    return 0;
        endcase
    endfunction

    function automatic int ppg(input int m);
        case (m)
            1, 6:    return 8;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        armed = 0; prev_h = 0; prev_v = 0;
        px_cnt = 0; line_cnt = 0;
        l_base = 0; l_stride = 0; l_hs = 0; l_vs = 0;
    endtask

    task automatic set_mode(input int m);
        cur_mode = m;
        bus.GPU_HW_Control_regs[CB] = {4'hA, 4'(m)};
    endtask

    task automatic set_regs(input int m, input logic [19:0] base, input logic [15:0] stride,
                            input int hs, input int vs);
        set_mode(m);
        r_base = longint'(base); r_stride = longint'(stride); r_hs = hs; r_vs = vs;
        bus.GPU_HW_Control_regs[CB+1] = {4'h7, base[19:16]};
        bus.GPU_HW_Control_regs[CB+2] = base[15:8];
        bus.GPU_HW_Control_regs[CB+3] = base[7:0];
        bus.GPU_HW_Control_regs[CB+4] = stride[15:8];
        bus.GPU_HW_Control_regs[CB+5] = stride[7:0];
        bus.GPU_HW_Control_regs[CB+6] = {4'h5, 4'(hs)};
        bus.GPU_HW_Control_regs[CB+7] = {4'h3, 4'(vs)};
    endtask

    // One pixel period: pc_ena==0 for one clk, then a non-zero phase for one clk.
    task automatic period(input bit h, input bit v);
        bit          act;
        dly_t        cur, ex;
        logic [19:0] ea;
        longint      off;
        bus.hde_in = h; bus.vde_in = v; bus.pc_ena = 4'd0;
        @(posedge clk); #1;
        s_ena = bus.read_ena; s_addr = bus.read_addr;
        s_pix = bus.pixel_out_ena; s_en = bus.enable_out; s_x = bus.x_out;

        act     = h && v && armed && (bpg(cur_mode) != 0);
        cur.pix = h && v && armed;
        cur.en  = act;
        cur.x   = 10'(px_cnt / (l_hs + 1));
        hist.push_back(cur);
        if (hist.size() > PD) ex = hist.pop_front();
        else ex = '{1'b0, 1'b0, 10'd0};

        check("read_ena", 32'(s_ena), 32'(act));
        if (act) begin
            off = longint'((px_cnt / (l_hs + 1)) / ppg(cur_mode)) * bpg(cur_mode);
            ea  = 20'(l_base + longint'(line_cnt / (l_vs + 1)) * l_stride + off);
            check("read_addr", 32'(s_addr), 32'(ea));
            px_cnt++;
        end
        check("pixel_out_ena", 32'(s_pix), 32'(ex.pix));
        check("enable_out", 32'(s_en), 32'(ex.en));
        check("x_out", 32'(s_x), 32'(ex.x));

        if (prev_h && !h && prev_v) begin
            px_cnt = 0; line_cnt++;
        end
        if (prev_v && !v) begin
            px_cnt = 0; line_cnt = 0; armed = 1;
            l_base = r_base; l_stride = r_stride; l_hs = r_hs; l_vs = r_vs;
        end
        prev_h = h; prev_v = v;

        bus.pc_ena = 4'd1;
        @(posedge clk); #1;
        check("read_ena_strobe", 32'(bus.read_ena), 32'd0);
    endtask

    task automatic frame_start();
        period(1'b0, 1'b1);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          mode;
        logic [19:0] base;
        logic [15:0] stride;
        int          hs, vs, npx;
        logic [19:0] f0, f1, f2, f3;
        logic [19:0] last0;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vec_t        v;
        logic [19:0] firsts[4];
        logic [19:0] a0;
        int          m, npx, nl, cnt;
        bit          seen;

        vecs[0] = '{4, 20'h01000, 16'd640,  0, 0, 640, 20'h01000, 20'h01280, 20'h01500, 20'h01780, 20'h0127F};
        vecs[1] = '{1, 20'h02000, 16'd80,   1, 0, 640, 20'h02000, 20'h02050, 20'h020A0, 20'h020F0, 20'h02027};
        vecs[2] = '{5, 20'h04000, 16'h0500, 0, 2, 64,  20'h04000, 20'h04000, 20'h04000, 20'h04500, 20'h0407E};
        vecs[3] = '{4, 20'hFFFF0, 16'h0020, 0, 0, 32,  20'hFFFF0, 20'h00010, 20'h00030, 20'h00050, 20'h0000F};
        vecs[4] = '{6, 20'h08000, 16'h0100, 0, 1, 64,  20'h08000, 20'h08000, 20'h08100, 20'h08100, 20'h0800E};
        vecs[5] = '{2, 20'h0ABCD, 16'h0010, 2, 0, 48,  20'h0ABCD, 20'h0ABDD, 20'h0ABED, 20'h0ABFD, 20'h0ABD0};

        for (int i = 0; i < 2 ** HWR; i++) bus.GPU_HW_Control_regs[i] = 8'hFF;
        bus.pc_ena = 4'd1; bus.hde_in = 1'b0; bus.vde_in = 1'b0;
        cur_mode = 0; r_base = 0; r_stride = 0; r_hs = 0; r_vs = 0;
        model_reset();

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_addr", 32'(bus.read_addr), 32'd0);
        check("rst_read_ena", 32'(bus.read_ena), 32'd0);
        check("rst_pixel_out_ena", 32'(bus.pixel_out_ena), 32'd0);
        check("rst_enable_out", 32'(bus.enable_out), 32'd0);
        check("rst_x_out", 32'(bus.x_out), 32'd0);
        reset_n = 1'b1;

        // Table-driven frames: four lines each, first/last addresses against constants.
        for (int r = 0; r < 6; r++) begin
            v = vecs[r];
            firsts[0] = v.f0; firsts[1] = v.f1; firsts[2] = v.f2; firsts[3] = v.f3;
            set_regs(v.mode, v.base, v.stride, v.hs, v.vs);
            frame_start();
            for (int ln = 0; ln < 4; ln++) begin
                for (int p = 0; p < v.npx; p++) begin
                    period(1'b1, 1'b1);
                    if (p == 0) check($sformatf("tbl%0d_line%0d_first", r, ln), 32'(s_addr), 32'(firsts[ln]));
                    if (ln == 0 && p == v.npx - 1) check($sformatf("tbl%0d_line0_last", r), 32'(s_addr), 32'(v.last0));
                end
                period(1'b0, 1'b1);
                period(1'b0, 1'b1);
            end
        end

        // Mode off, then switched on mid-line; base change waits for next frame.
        set_regs(0, 20'h30000, 16'h0040, 0, 0);
        frame_start();
        for (int p = 0; p < 4; p++) period(1'b1, 1'b1);
        check("mode0_read_ena", 32'(s_ena), 32'd0);
        check("mode0_enable_out", 32'(s_en), 32'd0);
        check("mode0_pixel_out_ena", 32'(s_pix), 32'd1);
        set_mode(4);
        r_base = 64'h50000;
        bus.GPU_HW_Control_regs[CB+1] = 8'h05;
        bus.GPU_HW_Control_regs[CB+2] = 8'h00;
        bus.GPU_HW_Control_regs[CB+3] = 8'h00;
        period(1'b1, 1'b1);
        check("mode_switch_first_read", 32'(s_ena), 32'd1);
        check("mode_switch_old_base", 32'(s_addr), 32'h30000);
        for (int p = 0; p < 7; p++) period(1'b1, 1'b1);
        period(1'b0, 1'b1);
        frame_start();
        period(1'b1, 1'b1);
        check("new_base_next_frame", 32'(s_addr), 32'h50000);
        period(1'b0, 1'b1);

        // Asynchronous reset in the middle of an active line.
        set_regs(4, 20'h12345, 16'h0100, 0, 0);
        frame_start();
        for (int p = 0; p < 6; p++) period(1'b1, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_read_addr", 32'(bus.read_addr), 32'd0);
        check("midrst_read_ena", 32'(bus.read_ena), 32'd0);
        check("midrst_pixel_out_ena", 32'(bus.pixel_out_ena), 32'd0);
        check("midrst_enable_out", 32'(bus.enable_out), 32'd0);
        check("midrst_x_out", 32'(bus.x_out), 32'd0);
        model_reset();
        #3 reset_n = 1'b1;
        for (int p = 0; p < 4; p++) period(1'b1, 1'b1);
        period(1'b0, 1'b1);
        frame_start();
        seen = 0;
        for (int p = 0; p < 10 && !seen; p++) begin
            period(1'b1, 1'b1);
            seen = s_ena;
        end
        check("resume_first_read", 32'(seen), 32'd1);
        if (seen) a0 = s_addr;
        else a0 = 20'h0;
        check("resume_addr", 32'(a0), 32'h12345);
        cnt = 0;
        for (int p = 0; p < 10; p++) begin
            period(1'b1, 1'b1);
            cnt++;
            if (s_pix) break;
        end
        check("resume_pixel_out_delay", 32'(cnt), 32'(PD));
        period(1'b0, 1'b1);

        // Random frames against the model.
        for (int f = 0; f < 16; f++) begin
            m   = int'($urandom_range(0, 7));
            npx = int'($urandom_range(4, 40));
            nl  = int'($urandom_range(2, 5));
            set_regs(m, 20'($urandom), 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            frame_start();
            for (int ln = 0; ln < nl; ln++) begin
                for (int p = 0; p < npx; p++) period(1'b1, 1'b1);
                if (ln == nl - 1 && $urandom_range(0, 1) == 1) begin
                    period(1'b0, 1'b0);
                end else begin
                    period(1'b0, 1'b1);
                    period(1'b0, 1'b1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
